program_checker: RTL and testbench

Synthesizable, parametrised self-checking monitor for the RISC-V `CHIP` core. It watches the instruction-address bus and the `a0` result register and compares `a0` against a table of expected answers at each arrival at a check PC. It declares pass or fail at a finish PC and flags cycle-limit timeouts and hung-PC conditions. It sits beside `CHIP` in simulation and FPGA bring-up, replacing ad-hoc testbench checking with one reusable block.

---
 rtl/riscv_tb_pkg.sv | 20 ++
 rtl/program_checker_if.sv | 39 +++
 rtl/program_checker_pc_watchdog.sv | 63 ++++++
 rtl/program_checker.sv | 164 ++++++++++++++++
 tb/tb_program_checker.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_tb_pkg.sv
`default_nettype none
// ============================================================================
//  riscv_tb_pkg
//  Shared state encoding and default addresses for the program checker.
//  Rev 1.0
// ============================================================================
package riscv_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] c_check_pc  = 32'h0000_00a8;
    localparam logic [31:0] c_finish_pc = 32'h0000_00c0;
    localparam int          c_end_cycle = 2800;

endpackage
`default_nettype wire

// File: rtl/program_checker_if.sv
`default_nettype none
// ============================================================================
//  program_checker_if
//  Core-facing bus and result signals of the program checker.
//  Rev 1.0
// ============================================================================
interface program_checker_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_CHECK = 4,
    parameter int CNT_W   = 16
);
    localparam int ERR_W = $clog2(N_CHECK + 2);
    localparam int IDX_W = $clog2(N_CHECK + 1);

    logic                      start_i;
    logic                      ack_i;
    logic [ADDR_W-1:0]         mem_addr_I;
    logic [DATA_W-1:0]         result_i;
    logic [N_CHECK*DATA_W-1:0] expect_i;
    logic                      done_o;
    logic                      pass_o;
    logic                      timeout_o;
    logic                      hang_o;
    logic [ERR_W-1:0]          err_cnt_o;
    logic [IDX_W-1:0]          check_idx_o;
    logic [CNT_W-1:0]          cycle_cnt_o;

    modport master (
        output start_i, ack_i, mem_addr_I, result_i, expect_i,
        input  done_o, pass_o, timeout_o, hang_o, err_cnt_o, check_idx_o, cycle_cnt_o
    );

    modport slave (
        input  start_i, ack_i, mem_addr_I, result_i, expect_i,
        output done_o, pass_o, timeout_o, hang_o, err_cnt_o, check_idx_o, cycle_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/program_checker_pc_watchdog.sv
`default_nettype none
// ============================================================================
//  pc_watchdog
//  Rising-edge detect on the check address and stuck-PC counter.
//  Rev 1.0
// ============================================================================
module pc_watchdog #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] CHECK_PC    = ADDR_W'(32'h0000_00a8),
    parameter int                HANG_CYCLES = 64
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_run,
    input  wire logic [ADDR_W-1:0] i_addr,
    output logic                   check_evt,
    output logic                   hang_evt
);

    logic [ADDR_W-1:0] r_prev_addr;
    logic              w_same;

    assign w_same = (i_addr == r_prev_addr);

    // Outside RUN the previous address parks at all-ones so the first RUN
    // cycle sitting on the check address still registers as an arrival.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_addr <= '1;
        end else if (!i_run) begin
            r_prev_addr <= '1;
        end else begin
            r_prev_addr <= i_addr;
        end
    end

    assign check_evt = i_run && (i_addr == CHECK_PC) && !w_same;

    generate
        if (HANG_CYCLES > 0) begin : g_hang
            localparam int HW = $clog2(HANG_CYCLES + 1);
            localparam logic [HW-1:0] c_hang_last = HW'(HANG_CYCLES - 1);

            logic [HW-1:0] r_hang_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hang_cnt <= '0;
                end else if (!i_run || !w_same) begin
                    r_hang_cnt <= '0;
                end else if (r_hang_cnt != c_hang_last) begin
                    r_hang_cnt <= r_hang_cnt + 1'b1;
                end
            end

            assign hang_evt = i_run && w_same && (r_hang_cnt == c_hang_last);
        end else begin : g_no_hang
            assign hang_evt = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/program_checker.sv
`default_nettype none
// ============================================================================
//  program_checker
//  Compares a0 against expected answers at each check-PC arrival and reports
//  pass/fail, timeout or hang when the run ends.
//  Rev 1.0
// ============================================================================
module program_checker
    import riscv_tb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                N_CHECK     = 4,
    parameter logic [ADDR_W-1:0] CHECK_PC    = ADDR_W'(c_check_pc),
    parameter logic [ADDR_W-1:0] FINISH_PC   = ADDR_W'(c_finish_pc),
    parameter int                END_CYCLE   = c_end_cycle,
    parameter int                CNT_W       = 16,
    parameter int                HANG_CYCLES = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    program_checker_if.slave bus
);

    localparam int ERR_W = $clog2(N_CHECK + 2);
    localparam int IDX_W = $clog2(N_CHECK + 1);
    localparam logic [IDX_W-1:0] c_idx_full = IDX_W'(N_CHECK);
    localparam logic [CNT_W-1:0] c_cyc_last = CNT_W'(END_CYCLE - 1);

    state_t            r_state;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic              r_hang;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [IDX_W-1:0]  r_check_idx;
    logic [CNT_W-1:0]  r_cycle_cnt;

    logic              w_run;
    logic              w_check_evt;
    logic              w_hang_evt;
    logic              w_finish;
    logic              w_timeout;
    logic              w_idx_full;
    logic              w_mismatch;
    logic [ERR_W-1:0]  w_err_inc;
    logic [DATA_W-1:0] w_expected;

    assign w_run = (r_state == ST_RUN);

    pc_watchdog #(
        .ADDR_W      (ADDR_W),
        .CHECK_PC    (CHECK_PC),
        .HANG_CYCLES (HANG_CYCLES)
    ) u_pc_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_run),
        .i_addr    (bus.mem_addr_I),
        .check_evt (w_check_evt),
        .hang_evt  (w_hang_evt)
    );

    always_comb begin
        w_expected = '0;
        for (int k = 0; k < N_CHECK; k++) begin
            if (r_check_idx == IDX_W'(k)) begin
                w_expected = bus.expect_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_finish   = (bus.mem_addr_I == FINISH_PC);
    assign w_timeout  = (r_cycle_cnt == c_cyc_last);
    assign w_idx_full = (r_check_idx == c_idx_full);
    assign w_mismatch = (bus.result_i != w_expected);
    assign w_err_inc  = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_hang      <= 1'b0;
            r_err_cnt   <= '0;
            r_check_idx <= '0;
            r_cycle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done      <= 1'b0;
                    r_pass      <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_hang      <= 1'b0;
                    r_err_cnt   <= '0;
                    r_check_idx <= '0;
                    r_cycle_cnt <= '0;
                    if (bus.start_i) begin
                        r_state     <= ST_RUN;
                        r_cycle_cnt <= CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + 1'b1;
                    // Arrivals past the last table entry count as errors.
                    if (w_check_evt) begin
                        if (w_idx_full) begin
                            r_err_cnt <= w_err_inc;
                        end else begin
                            if (w_mismatch) begin
                                r_err_cnt <= w_err_inc;
                            end
                            r_check_idx <= r_check_idx + 1'b1;
                        end
                    end
                    // Check and finish addresses differ, so pass uses the
                    // settled counters.
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_cnt == '0) && w_idx_full;
                    end else if (w_timeout) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (w_hang_evt) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_hang  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (bus.ack_i) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_hang      <= 1'b0;
                        r_err_cnt   <= '0;
                        r_check_idx <= '0;
                        r_cycle_cnt <= '0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.done_o      = r_done;
    assign bus.pass_o      = r_pass;
    assign bus.timeout_o   = r_timeout;
    assign bus.hang_o      = r_hang;
    assign bus.err_cnt_o   = r_err_cnt;
    assign bus.check_idx_o = r_check_idx;
    assign bus.cycle_cnt_o = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_program_checker.sv
`default_nettype none
// ============================================================================
//  tb_program_checker
//  Three checker instances share one stimulus stream; a reference model feeds
//  per-instance expectation queues that are drained when a run ends.
//  Rev 1.0
// ============================================================================
module tb_program_checker;

    localparam logic [31:0] CHK = 32'h0000_00a8;
    localparam logic [31:0] FIN = 32'h0000_00c0;

    typedef struct {
        logic pass;
        logic to;
        logic hang;
        int   err;
        int   idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, ack;
    logic [31:0] addr, res;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    int          m_err_a, m_idx_a, m_err_b, m_idx_b;
    logic        in_run;
    logic [31:0] tb_prev;
    int          tb_cyc;

    always #5 clk = ~clk;

    // A: 3 entries, no hang detect; B: 1 entry, no hang detect; H: 3 entries, hang after 8
    program_checker_if #(.ADDR_W(32), .DATA_W(32), .N_CHECK(3), .CNT_W(16)) bus_a ();
    program_checker_if #(.ADDR_W(32), .DATA_W(32), .N_CHECK(1), .CNT_W(16)) bus_b ();
    program_checker_if #(.ADDR_W(32), .DATA_W(32), .N_CHECK(3), .CNT_W(16)) bus_h ();

    assign bus_a.start_i = start;  assign bus_a.ack_i = ack;
    assign bus_a.mem_addr_I = addr; assign bus_a.result_i = res;
    assign bus_a.expect_i = {32'd120, 32'd24, 32'd6};
    assign bus_b.start_i = start;  assign bus_b.ack_i = ack;
    assign bus_b.mem_addr_I = addr; assign bus_b.result_i = res;
    assign bus_b.expect_i = 32'd55;
    assign bus_h.start_i = start;  assign bus_h.ack_i = ack;
    assign bus_h.mem_addr_I = addr; assign bus_h.result_i = res;
    assign bus_h.expect_i = {32'd120, 32'd24, 32'd6};

    program_checker #(.ADDR_W(32), .DATA_W(32), .N_CHECK(3), .CHECK_PC(CHK), .FINISH_PC(FIN),
                      .END_CYCLE(100), .CNT_W(16), .HANG_CYCLES(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    program_checker #(.ADDR_W(32), .DATA_W(32), .N_CHECK(1), .CHECK_PC(CHK), .FINISH_PC(FIN),
                      .END_CYCLE(100), .CNT_W(16), .HANG_CYCLES(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    program_checker #(.ADDR_W(32), .DATA_W(32), .N_CHECK(3), .CHECK_PC(CHK), .FINISH_PC(FIN),
                      .END_CYCLE(100), .CNT_W(16), .HANG_CYCLES(8))
        dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));

    // ---------------- reference model and stimulus helpers ----------------
    task automatic model_check(input logic [31:0] r);
        logic [31:0] exp_a [3];
        exp_a[0] = 32'd6; exp_a[1] = 32'd24; exp_a[2] = 32'd120;
        if (m_idx_a < 3) begin
            if (r != exp_a[m_idx_a]) m_err_a = (m_err_a < 7) ? m_err_a + 1 : 7;
            m_idx_a++;
        end else begin
            m_err_a = (m_err_a < 7) ? m_err_a + 1 : 7;
        end
        if (m_idx_b < 1) begin
            if (r != 32'd55) m_err_b = (m_err_b < 3) ? m_err_b + 1 : 3;
            m_idx_b++;
        end else begin
            m_err_b = (m_err_b < 3) ? m_err_b + 1 : 3;
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] r);
        addr = a;
        res  = r;
        if (in_run && a == CHK && a != tb_prev) model_check(r);
        tb_prev = a;
        tb_cyc++;
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        addr  = 32'h0;
        @(posedge clk); #1;
        start   = 1'b0;
        tb_prev = '1;
        tb_cyc  = 1;
        m_err_a = 0; m_idx_a = 0; m_err_b = 0; m_idx_b = 0;
        in_run  = 1'b1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk); #1;
        ack    = 1'b0;
        in_run = 1'b0;
    endtask

    task automatic push_exp(input logic is_to);
        q_a.push_back('{pass: (!is_to && m_err_a == 0 && m_idx_a == 3), to: is_to, hang: 1'b0,
                        err: m_err_a, idx: m_idx_a});
        q_b.push_back('{pass: (!is_to && m_err_b == 0 && m_idx_b == 1), to: is_to, hang: 1'b0,
                        err: m_err_b, idx: m_idx_b});
    endtask

    task automatic run_three(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        drive(32'h10, 0); drive(CHK, r0);
        drive(32'h14, 0); drive(CHK, r1);
        drive(32'h18, 0); drive(CHK, r2);
        drive(32'h1c, 0);
    endtask

    // ---------------------------- tests ----------------------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ack = 1'b0; addr = '0; res = '0; in_run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus_a.done_o, bus_a.pass_o, bus_a.timeout_o, bus_a.hang_o, bus_a.err_cnt_o,
             bus_a.check_idx_o, bus_a.cycle_cnt_o} !== 25'd0) begin
            n_fail++; $display("FAIL reset_a: outputs not zero");
        end
        n_cmp++;
        if ({bus_b.done_o, bus_b.pass_o, bus_b.timeout_o, bus_b.hang_o, bus_b.err_cnt_o,
             bus_b.check_idx_o, bus_b.cycle_cnt_o} !== 23'd0) begin
            n_fail++; $display("FAIL reset_b: outputs not zero");
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_pass();
        exp_t e;
        logic [8:0] ga, wa;
        logic [6:0] gb, wb;
        do_start();
        n_cmp++;
        if (bus_a.cycle_cnt_o !== 16'd1) begin
            n_fail++; $display("FAIL cycle_first: got %0d want 1", bus_a.cycle_cnt_o);
        end
        drive(32'h10, 0);
        drive(CHK, 32'd55);
        n_cmp++;
        if ({bus_b.err_cnt_o, bus_b.check_idx_o} !== {2'(m_err_b), 1'(m_idx_b)}) begin
            n_fail++; $display("FAIL check_latency: got err=%0d idx=%0d want err=%0d idx=%0d",
                               bus_b.err_cnt_o, bus_b.check_idx_o, m_err_b, m_idx_b);
        end
        drive(32'h20, 0);
        push_exp(1'b0);
        drive(FIN, 0);
        e = q_a.pop_front(); n_cmp++;
        ga = {bus_a.done_o, bus_a.pass_o, bus_a.timeout_o, bus_a.hang_o, bus_a.err_cnt_o, bus_a.check_idx_o};
        wa = {1'b1, e.pass, e.to, e.hang, 3'(e.err), 2'(e.idx)};
        if (ga !== wa) begin n_fail++; $display("FAIL pass_run_a: got %b want %b", ga, wa); end
        e = q_b.pop_front(); n_cmp++;
        gb = {bus_b.done_o, bus_b.pass_o, bus_b.timeout_o, bus_b.hang_o, bus_b.err_cnt_o, bus_b.check_idx_o};
        wb = {1'b1, e.pass, e.to, e.hang, 2'(e.err), 1'(e.idx)};
        if (gb !== wb) begin n_fail++; $display("FAIL pass_run_b: got %b want %b", gb, wb); end
        // outputs must stay frozen in DONE, start ignored
        start = 1'b1;
        drive(CHK, 32'd1);
        start = 1'b0;
        drive(32'h10, 0);
        n_cmp++;
        gb = {bus_b.done_o, bus_b.pass_o, bus_b.timeout_o, bus_b.hang_o, bus_b.err_cnt_o, bus_b.check_idx_o};
        if (gb !== 7'b1100_001) begin n_fail++; $display("FAIL done_frozen: got %b want 1100001", gb); end
        do_ack();
        n_cmp++;
        if ({bus_b.done_o, bus_b.pass_o, bus_b.err_cnt_o, bus_b.check_idx_o, bus_b.cycle_cnt_o,
             bus_a.done_o} !== 22'd0) begin
            n_fail++; $display("FAIL ack_clear: done=%b err=%0d idx=%0d cyc=%0d",
                               bus_b.done_o, bus_b.err_cnt_o, bus_b.check_idx_o, bus_b.cycle_cnt_o);
        end
    endtask

    task automatic test_mismatch();
        exp_t e;
        logic [8:0] ga, wa;
        logic [6:0] gb, wb;
        do_start();
        run_three(32'd6, 32'd25, 32'd120);
        // start and ack in RUN must be ignored
        start = 1'b1; ack = 1'b1;
        drive(32'h24, 0);
        start = 1'b0; ack = 1'b0;
        n_cmp++;
        if ({bus_a.done_o, bus_a.cycle_cnt_o} !== {1'b0, 16'(tb_cyc)}) begin
            n_fail++; $display("FAIL run_ignores: got done=%b cyc=%0d want done=0 cyc=%0d",
                               bus_a.done_o, bus_a.cycle_cnt_o, tb_cyc);
        end
        push_exp(1'b0);
        drive(FIN, 0);
        e = q_a.pop_front(); n_cmp++;
        ga = {bus_a.done_o, bus_a.pass_o, bus_a.timeout_o, bus_a.hang_o, bus_a.err_cnt_o, bus_a.check_idx_o};
        wa = {1'b1, e.pass, e.to, e.hang, 3'(e.err), 2'(e.idx)};
        if (ga !== wa) begin n_fail++; $display("FAIL mismatch_a: got %b want %b", ga, wa); end
        e = q_b.pop_front(); n_cmp++;
        gb = {bus_b.done_o, bus_b.pass_o, bus_b.timeout_o, bus_b.hang_o, bus_b.err_cnt_o, bus_b.check_idx_o};
        wb = {1'b1, e.pass, e.to, e.hang, 2'(e.err), 1'(e.idx)};
        if (gb !== wb) begin n_fail++; $display("FAIL mismatch_b: got %b want %b", gb, wb); end
        do_ack();
    endtask

    task automatic test_stall_overrun();
        exp_t e;
        logic [8:0] ga, wa;
        logic [6:0] gb, wb;
        do_start();
        drive(32'h10, 0);
        for (int i = 0; i < 10; i++) drive(CHK, 32'd6);
        n_cmp++;
        if ({bus_a.err_cnt_o, bus_a.check_idx_o} !== 5'b000_01) begin
            n_fail++; $display("FAIL stall_single: got err=%0d idx=%0d want err=0 idx=1",
                               bus_a.err_cnt_o, bus_a.check_idx_o);
        end
        drive(32'h10, 0); drive(CHK, 32'd24);
        drive(32'h14, 0); drive(CHK, 32'd120);
        drive(32'h18, 0); drive(CHK, 32'd0);
        n_cmp++;
        if ({bus_a.err_cnt_o, bus_a.check_idx_o} !== {3'(m_err_a), 2'(m_idx_a)}) begin
            n_fail++; $display("FAIL overrun: got err=%0d idx=%0d want err=%0d idx=%0d",
                               bus_a.err_cnt_o, bus_a.check_idx_o, m_err_a, m_idx_a);
        end
        drive(32'h1c, 0);
        push_exp(1'b0);
        drive(FIN, 0);
        e = q_a.pop_front(); n_cmp++;
        ga = {bus_a.done_o, bus_a.pass_o, bus_a.timeout_o, bus_a.hang_o, bus_a.err_cnt_o, bus_a.check_idx_o};
        wa = {1'b1, e.pass, e.to, e.hang, 3'(e.err), 2'(e.idx)};
        if (ga !== wa) begin n_fail++; $display("FAIL overrun_fin_a: got %b want %b", ga, wa); end
        e = q_b.pop_front(); n_cmp++;
        gb = {bus_b.done_o, bus_b.pass_o, bus_b.timeout_o, bus_b.hang_o, bus_b.err_cnt_o, bus_b.check_idx_o};
        wb = {1'b1, e.pass, e.to, e.hang, 2'(e.err), 1'(e.idx)};
        if (gb !== wb) begin n_fail++; $display("FAIL saturate_b: got %b want %b", gb, wb); end
        do_ack();
    endtask

    task automatic test_timeout(input logic finish_at_limit);
        exp_t e;
        logic [8:0] ga, wa;
        logic [6:0] gb, wb;
        do_start();
        run_three(32'd6, 32'd24, 32'd120);
        while (tb_cyc < 99) drive(tb_cyc[0] ? 32'h30 : 32'h34, 0);
        n_cmp++;
        if ({bus_a.done_o, bus_a.cycle_cnt_o} !== {1'b0, 16'd99}) begin
            n_fail++; $display("FAIL cycle_limit: got done=%b cyc=%0d want done=0 cyc=99",
                               bus_a.done_o, bus_a.cycle_cnt_o);
        end
        push_exp(!finish_at_limit);
        drive(finish_at_limit ? FIN : 32'h38, 0);
        e = q_a.pop_front(); n_cmp++;
        ga = {bus_a.done_o, bus_a.pass_o, bus_a.timeout_o, bus_a.hang_o, bus_a.err_cnt_o, bus_a.check_idx_o};
        wa = {1'b1, e.pass, e.to, e.hang, 3'(e.err), 2'(e.idx)};
        if (ga !== wa) begin
            n_fail++; $display("FAIL timeout_a(fin=%0b): got %b want %b", finish_at_limit, ga, wa);
        end
        e = q_b.pop_front(); n_cmp++;
        gb = {bus_b.done_o, bus_b.pass_o, bus_b.timeout_o, bus_b.hang_o, bus_b.err_cnt_o, bus_b.check_idx_o};
        wb = {1'b1, e.pass, e.to, e.hang, 2'(e.err), 1'(e.idx)};
        if (gb !== wb) begin
            n_fail++; $display("FAIL timeout_b(fin=%0b): got %b want %b", finish_at_limit, gb, wb);
        end
        do_ack();
    endtask

    task automatic test_hang();
        exp_t e;
        logic [8:0] ga, wa;
        logic found;
        int   n;
        found = 1'b0; n = 0;
        do_start();
        for (int i = 1; i <= 20; i++) begin
            drive(32'h40, 0);
            if (bus_h.done_o === 1'b1) begin found = 1'b1; n = i; break; end
        end
        n_cmp++;
        if (!found || n < 8 || n > 10) begin
            n_fail++; $display("FAIL hang_latency: found=%b after %0d frozen cycles, want 8..10", found, n);
        end
        n_cmp++;
        if ({bus_h.done_o, bus_h.pass_o, bus_h.timeout_o, bus_h.hang_o} !== 4'b1001) begin
            n_fail++; $display("FAIL hang_flags: got %b want 1001",
                               {bus_h.done_o, bus_h.pass_o, bus_h.timeout_o, bus_h.hang_o});
        end
        n_cmp++;
        if (bus_a.done_o !== 1'b0) begin
            n_fail++; $display("FAIL hang_disabled: got done=%b want 0", bus_a.done_o);
        end
        while (tb_cyc < 99) drive(32'h40, 0);
        push_exp(1'b1);
        drive(32'h40, 0);
        e = q_a.pop_front(); n_cmp++;
        ga = {bus_a.done_o, bus_a.pass_o, bus_a.timeout_o, bus_a.hang_o, bus_a.err_cnt_o, bus_a.check_idx_o};
        wa = {1'b1, e.pass, e.to, e.hang, 3'(e.err), 2'(e.idx)};
        if (ga !== wa) begin n_fail++; $display("FAIL nohang_timeout_a: got %b want %b", ga, wa); end
        e = q_b.pop_front();
        do_ack();
    endtask

    task automatic test_reset_midrun();
        do_start();
        drive(32'h10, 0); drive(CHK, 32'd6); drive(32'h14, 0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_a.done_o, bus_a.pass_o, bus_a.timeout_o, bus_a.hang_o, bus_a.err_cnt_o,
             bus_a.check_idx_o, bus_a.cycle_cnt_o} !== 25'd0) begin
            n_fail++; $display("FAIL reset_midrun: idx=%0d cyc=%0d want 0",
                               bus_a.check_idx_o, bus_a.cycle_cnt_o);
        end
        @(posedge clk); #1;
        rst_n  = 1'b1;
        in_run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_mismatch();
        test_stall_overrun();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_hang();
        test_reset_midrun();
        test_single_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
